// File: rtl/rsa_keygen_ext_if.sv
// Request/result bundle between the RSA key generator and its requester.
interface rsa_keygen_ext_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic                   mode;
    logic [WIDTH-1:0]       p;
    logic [WIDTH-1:0]       q;
    logic [2*WIDTH-1:0]     e_in;
    logic                   busy;
    logic                   finish;
    logic                   error;
    logic [2*WIDTH-1:0]     n;
    logic [2*WIDTH-1:0]     phi;
    logic [2*WIDTH-1:0]     e;
    logic [2*WIDTH-1:0]     d;

    modport master (
        output start, mode, p, q, e_in,
        input  busy, finish, error, n, phi, e, d
    );

    modport slave (
        input  start, mode, p, q, e_in,
        output busy, finish, error, n, phi, e, d
    );
endinterface

// File: rtl/rsa_keygen_ext.sv
// RSA key generator: n, phi, public exponent e (searched or supplied) and
// private exponent d = e^-1 mod phi via subtractive extended Euclid.
module rsa_keygen_ext #(
    parameter int WIDTH   = 8,
    parameter int E_START = 3,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    rsa_keygen_ext_if.slave   bus
);
    localparam int WW = 2 * WIDTH;
    localparam int TW = WW + 2;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [WIDTH-1:0] P_MIN     = WIDTH'(2);
    localparam logic [WW-1:0]    ZERO_W    = {WW{1'b0}};
    localparam logic [WW-1:0]    ONE_W     = WW'(1);
    localparam logic [WW-1:0]    THREE_W   = WW'(3);
    localparam logic [WW-1:0]    E_START_W = WW'(E_START);
    localparam logic [CW-1:0]    WD_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]    WD_ONE    = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CALC    = 3'd1,
        S_CHECK   = 3'd2,
        S_EU_INIT = 3'd3,
        S_EU_STEP = 3'd4,
        S_EVAL    = 3'd5,
        S_NEXT_E  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       p_q, p_d, q_q, q_d;
    logic                   mode_q, mode_d;
    logic [WW-1:0]          e_in_q, e_in_d;
    logic [WW-1:0]          n_q, n_d, phi_q, phi_d, e_q, e_d, d_q, d_d;
    logic [WW-1:0]          cand_q, cand_d, a_q, a_d, b_q, b_d;
    logic signed [TW-1:0]   ta_q, ta_d, tb_q, tb_d;
    logic                   busy_q, busy_d, finish_q, finish_d, err_q, err_d;
    logic [CW-1:0]          wd_q, wd_d;

    logic                   chk_err_s;
    logic                   eval_ok_s;
    logic [WW-1:0]          cand_inc_s;
    logic                   next_over_s;
    logic                   wd_expire_s;
    logic signed [TW-1:0]   ta_fix_s;
    logic [WW-1:0]          p_ext_s, q_ext_s;

    assign p_ext_s     = {{WIDTH{1'b0}}, p_q};
    assign q_ext_s     = {{WIDTH{1'b0}}, q_q};
    // Invalid primes, out-of-range fixed exponent, or no room for a search.
    assign chk_err_s   = (p_q < P_MIN) || (q_q < P_MIN) ||
                         (mode_q ? ((e_in_q < THREE_W) || (e_in_q >= phi_q))
                                 : (E_START_W >= phi_q));
    assign eval_ok_s   = (a_q == ONE_W);
    assign cand_inc_s  = cand_q + ONE_W;
    assign next_over_s = (cand_inc_s >= phi_q);
    assign wd_expire_s = (wd_q >= WD_LAST) && (state_q != S_IDLE) && (state_q != S_DONE);
    // Negative inverse coefficient is folded back into [0, phi).
    assign ta_fix_s    = ta_q + $signed({2'b00, phi_q});

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            p_q      <= {WIDTH{1'b0}};
            q_q      <= {WIDTH{1'b0}};
            mode_q   <= 1'b0;
            e_in_q   <= ZERO_W;
            n_q      <= ZERO_W;
            phi_q    <= ZERO_W;
            e_q      <= ZERO_W;
            d_q      <= ZERO_W;
            cand_q   <= ZERO_W;
            a_q      <= ZERO_W;
            b_q      <= ZERO_W;
            ta_q     <= {TW{1'b0}};
            tb_q     <= {TW{1'b0}};
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            err_q    <= 1'b0;
            wd_q     <= {CW{1'b0}};
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            q_q      <= q_d;
            mode_q   <= mode_d;
            e_in_q   <= e_in_d;
            n_q      <= n_d;
            phi_q    <= phi_d;
            e_q      <= e_d;
            d_q      <= d_d;
            cand_q   <= cand_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ta_q     <= ta_d;
            tb_q     <= tb_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
            err_q    <= err_d;
            wd_q     <= wd_d;
        end
    end

    // Next-state selection; the watchdog overrides every working state.
    always_comb begin
        state_d = state_q;
        if (wd_expire_s) begin
            state_d = S_DONE;
        end else begin
            case (state_q)
                S_IDLE:    state_d = bus.start ? S_CALC : S_IDLE;
                S_CALC:    state_d = S_CHECK;
                S_CHECK:   state_d = chk_err_s ? S_DONE : S_EU_INIT;
                S_EU_INIT: state_d = S_EU_STEP;
                S_EU_STEP: state_d = (b_q == ZERO_W) ? S_EVAL : S_EU_STEP;
                S_EVAL:    state_d = (eval_ok_s || mode_q) ? S_DONE : S_NEXT_E;
                S_NEXT_E:  state_d = next_over_s ? S_DONE : S_EU_INIT;
                S_DONE:    state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and output register next values for the current state.
    always_comb begin
        p_d      = p_q;
        q_d      = q_q;
        mode_d   = mode_q;
        e_in_d   = e_in_q;
        n_d      = n_q;
        phi_d    = phi_q;
        e_d      = e_q;
        d_d      = d_q;
        cand_d   = cand_q;
        a_d      = a_q;
        b_d      = b_q;
        ta_d     = ta_q;
        tb_d     = tb_q;
        err_d    = err_q;
        busy_d   = (state_d != S_IDLE) && (state_d != S_DONE);
        finish_d = (state_d == S_DONE);
        wd_d     = (state_q == S_IDLE) ? {CW{1'b0}} : (wd_q + WD_ONE);
        if (wd_expire_s) begin
            err_d = 1'b1;
            e_d   = ZERO_W;
            d_d   = ZERO_W;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        p_d    = bus.p;
                        q_d    = bus.q;
                        mode_d = bus.mode;
                        e_in_d = bus.e_in;
                        err_d  = 1'b0;
                        e_d    = ZERO_W;
                        d_d    = ZERO_W;
                    end else begin
                        err_d  = err_q;
                    end
                end
                S_CALC: begin
                    n_d   = p_ext_s * q_ext_s;
                    phi_d = (p_ext_s - ONE_W) * (q_ext_s - ONE_W);
                end
                S_CHECK: begin
                    cand_d = mode_q ? e_in_q : E_START_W;
                    if (chk_err_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = 1'b0;
                    end
                end
                S_EU_INIT: begin
                    a_d  = phi_q;
                    ta_d = {TW{1'b0}};
                    b_d  = cand_q;
                    tb_d = {{(TW-1){1'b0}}, 1'b1};
                end
                S_EU_STEP: begin
                    if (b_q == ZERO_W) begin
                        a_d = a_q;
                    end else if (a_q >= b_q) begin
                        a_d  = a_q - b_q;
                        ta_d = ta_q - tb_q;
                    end else begin
                        a_d  = b_q;
                        ta_d = tb_q;
                        b_d  = a_q;
                        tb_d = ta_q;
                    end
                end
                S_EVAL: begin
                    if (eval_ok_s) begin
                        e_d = cand_q;
                        d_d = ta_q[TW-1] ? ta_fix_s[WW-1:0] : ta_q[WW-1:0];
                    end else if (mode_q) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = 1'b0;
                    end
                end
                S_NEXT_E: begin
                    if (next_over_s) begin
                        err_d = 1'b1;
                    end else begin
                        cand_d = cand_inc_s;
                    end
                end
                S_DONE: begin
                    err_d = err_q;
                end
                default: begin
                    err_d = err_q;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.finish = finish_q;
    assign bus.error  = err_q;
    assign bus.n      = n_q;
    assign bus.phi    = phi_q;
    assign bus.e      = e_q;
    assign bus.d      = d_q;
endmodule

// File: tb/tb_rsa_keygen_ext.sv
// Directed bench for rsa_keygen_ext: 8-bit instance for the main vectors,
// 16-bit instance with a short watchdog for wide values and timeout.
module tb_rsa_keygen_ext;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    rsa_keygen_ext_if #(.WIDTH(8))  bus8 ();
    rsa_keygen_ext_if #(.WIDTH(16)) bus16 ();

    rsa_keygen_ext #(.WIDTH(8), .E_START(3), .TIMEOUT(4096)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    rsa_keygen_ext #(.WIDTH(16), .E_START(3), .TIMEOUT(1000)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One key on the 8-bit instance; optionally pokes a second start while busy.
    task automatic run8(input string tag, input logic [7:0] pp, input logic [7:0] qq,
                        input logic md, input logic [15:0] ei, input bit poke,
                        input logic exp_err, input logic [15:0] exp_n, input logic [15:0] exp_phi,
                        input logic [15:0] exp_e, input logic [15:0] exp_d);
        int   pulses = 0;
        int   post   = 0;
        bit   seen   = 1'b0;
        logic c_busy = 1'b1;
        logic c_err  = 1'b0;
        logic [15:0] c_n = 16'd0, c_phi = 16'd0, c_e = 16'd0, c_d = 16'd0;
        @(negedge clk);
        bus8.p = pp; bus8.q = qq; bus8.mode = md; bus8.e_in = ei; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        check_val({tag, "_busy_after_start"}, 32'(bus8.busy), 32'd1);
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            bus8.start = 1'b0;
            if (bus8.finish) begin
                pulses++;
                seen   = 1'b1;
                c_busy = bus8.busy; c_err = bus8.error;
                c_n = bus8.n; c_phi = bus8.phi; c_e = bus8.e; c_d = bus8.d;
                // start coinciding with finish must be ignored
                bus8.start = 1'b1;
            end else if (seen) begin
                post++;
                if (post == 4) break;
            end else if (poke && i == 2) begin
                bus8.p = 8'd3; bus8.q = 8'd7; bus8.mode = 1'b0; bus8.start = 1'b1;
            end
        end
        bus8.start = 1'b0;
        check_val({tag, "_finish_pulses"}, 32'(pulses), 32'd1);
        check_val({tag, "_busy_at_finish"}, 32'(c_busy), 32'd0);
        check_val({tag, "_error"}, 32'(c_err), 32'(exp_err));
        check_val({tag, "_n"}, 32'(c_n), 32'(exp_n));
        check_val({tag, "_phi"}, 32'(c_phi), 32'(exp_phi));
        check_val({tag, "_e"}, 32'(c_e), 32'(exp_e));
        check_val({tag, "_d"}, 32'(c_d), 32'(exp_d));
        check_val({tag, "_idle_busy"}, 32'(bus8.busy), 32'd0);
        check_val({tag, "_hold_e"}, 32'(bus8.e), 32'(exp_e));
        check_val({tag, "_hold_err"}, 32'(bus8.error), 32'(exp_err));
    endtask

    // One key on the 16-bit instance.
    task automatic run16(input string tag, input logic [15:0] pp, input logic [15:0] qq,
                         input logic md, input logic [31:0] ei,
                         input logic exp_err, input logic [31:0] exp_n, input logic [31:0] exp_phi,
                         input logic [31:0] exp_e, input logic [31:0] exp_d);
        int pulses = 0;
        int post   = 0;
        bit seen   = 1'b0;
        logic c_err = 1'b0;
        logic [31:0] c_n = 32'd0, c_phi = 32'd0, c_e = 32'd0, c_d = 32'd0;
        @(negedge clk);
        bus16.p = pp; bus16.q = qq; bus16.mode = md; bus16.e_in = ei; bus16.start = 1'b1;
        @(negedge clk);
        bus16.start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus16.finish) begin
                pulses++;
                seen = 1'b1;
                c_err = bus16.error;
                c_n = bus16.n; c_phi = bus16.phi; c_e = bus16.e; c_d = bus16.d;
            end else if (seen) begin
                post++;
                if (post == 3) break;
            end
        end
        check_val({tag, "_finish_pulses"}, 32'(pulses), 32'd1);
        check_val({tag, "_error"}, 32'(c_err), 32'(exp_err));
        check_val({tag, "_n"}, c_n, exp_n);
        check_val({tag, "_phi"}, c_phi, exp_phi);
        check_val({tag, "_e"}, c_e, exp_e);
        check_val({tag, "_d"}, c_d, exp_d);
    endtask

    initial begin
        rst_n = 1'b0;
        bus8.start = 1'b0;  bus8.mode = 1'b0;  bus8.p = 8'd0;   bus8.q = 8'd0;   bus8.e_in = 16'd0;
        bus16.start = 1'b0; bus16.mode = 1'b0; bus16.p = 16'd0; bus16.q = 16'd0; bus16.e_in = 32'd0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", 32'(bus8.busy), 32'd0);
        check_val("rst_finish", 32'(bus8.finish), 32'd0);
        check_val("rst_error", 32'(bus8.error), 32'd0);
        check_val("rst_n_out", 32'(bus8.n), 32'd0);
        check_val("rst_d", 32'(bus8.d), 32'd0);
        rst_n = 1'b1;

        run8("t1_5_11",    8'd5,  8'd11, 1'b0, 16'd0,  1'b0, 1'b0, 16'd55,  16'd40,  16'd3,  16'd27);
        run8("t2_3_7",     8'd3,  8'd7,  1'b0, 16'd0,  1'b0, 1'b0, 16'd21,  16'd12,  16'd5,  16'd5);
        run8("t3_fix7",    8'd5,  8'd11, 1'b1, 16'd7,  1'b0, 1'b0, 16'd55,  16'd40,  16'd7,  16'd23);
        run8("t3_fix5",    8'd5,  8'd11, 1'b1, 16'd5,  1'b0, 1'b1, 16'd55,  16'd40,  16'd0,  16'd0);
        run8("t3_fix3",    8'd5,  8'd11, 1'b1, 16'd3,  1'b0, 1'b0, 16'd55,  16'd40,  16'd3,  16'd27);
        run8("t3_fix39",   8'd5,  8'd11, 1'b1, 16'd39, 1'b0, 1'b0, 16'd55,  16'd40,  16'd39, 16'd39);
        run8("t3_fix40",   8'd5,  8'd11, 1'b1, 16'd40, 1'b0, 1'b1, 16'd55,  16'd40,  16'd0,  16'd0);
        run8("t3_fix2",    8'd5,  8'd11, 1'b1, 16'd2,  1'b0, 1'b1, 16'd55,  16'd40,  16'd0,  16'd0);
        run8("t4_2_3",     8'd2,  8'd3,  1'b0, 16'd0,  1'b0, 1'b1, 16'd6,   16'd2,   16'd0,  16'd0);
        run8("t4_1_7",     8'd1,  8'd7,  1'b0, 16'd0,  1'b0, 1'b1, 16'd7,   16'd0,   16'd0,  16'd0);
        run8("t6_7_13",    8'd7,  8'd13, 1'b0, 16'd0,  1'b0, 1'b0, 16'd91,  16'd72,  16'd5,  16'd29);
        run8("t6_11_13",   8'd11, 8'd13, 1'b0, 16'd0,  1'b0, 1'b0, 16'd143, 16'd120, 16'd7,  16'd103);
        run8("t6_2_7",     8'd2,  8'd7,  1'b0, 16'd0,  1'b0, 1'b0, 16'd14,  16'd6,   16'd5,  16'd5);
        run8("t6_poke",    8'd5,  8'd11, 1'b0, 16'd0,  1'b1, 1'b0, 16'd55,  16'd40,  16'd3,  16'd27);

        // Asynchronous reset in the middle of the Euclid loop.
        @(negedge clk);
        bus8.p = 8'd5; bus8.q = 8'd11; bus8.mode = 1'b0; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (6) @(negedge clk);
        check_val("t5_busy_before_rst", 32'(bus8.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_busy", 32'(bus8.busy), 32'd0);
        check_val("t5_rst_n", 32'(bus8.n), 32'd0);
        check_val("t5_rst_phi", 32'(bus8.phi), 32'd0);
        check_val("t5_rst_e", 32'(bus8.e), 32'd0);
        check_val("t5_rst_error", 32'(bus8.error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run8("t5_restart", 8'd5,  8'd11, 1'b0, 16'd0,  1'b0, 1'b0, 16'd55,  16'd40,  16'd3,  16'd27);

        run16("w16_17_19",  16'd17,  16'd19,  1'b0, 32'd0, 1'b0, 32'd323,   32'd288,   32'd5, 32'd173);
        run16("w16_wdog",   16'd251, 16'd241, 1'b1, 32'd7, 1'b1, 32'd60491, 32'd60000, 32'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
